// File: rtl/output_port_pkg.sv
// Shared constants for the OUT port: bus word size and default FIFO depth.
package output_port_pkg;

  localparam int unsigned WORD_SIZE      = 4;
  localparam int unsigned OUT_FIFO_DEPTH = 4;

endpackage

// File: rtl/output_port_fifo_ram.sv
// DEPTH x WIDTH register array for the OUT FIFO: synchronous write, asynchronous read.
module output_fifo_ram #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  // Storage is deliberately not reset; out_data is masked by occupancy upstream.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/output_port.sv
// OUT port: captures bus words into a small FIFO drained by the host over valid/ready,
// stalling control while full and flagging captures dropped while full.
module output_port
  import output_port_pkg::*;
#(
  parameter int unsigned WIDTH  = WORD_SIZE,
  parameter int unsigned DEPTH  = OUT_FIFO_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic [WIDTH-1:0]  bus_in,
  output logic              stall,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clear_overflow
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              full, push, pop, drop;
  logic [WIDTH-1:0]  ram_rdata;

  assign full      = (count_q == FullCount);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a capture while full is still accepted.
  assign push      = capture & (~full | pop);
  assign drop      = capture & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Set beats clear when both happen in one cycle.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  output_fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (bus_in),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Zero when empty so the word can be OR-combined onto a shared bus safely.
  assign out_data = out_valid ? ram_rdata : '0;
  assign stall    = full;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_output_port.sv
// Scoreboard bench for output_port: directed captures queue expected words,
// a negedge monitor checks every popped word against the queue.
module tb_output_port;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              capture;
  logic [WIDTH-1:0]  bus_in;
  logic              stall;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              clear_overflow;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  output_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .capture        (capture),
    .bus_in         (bus_in),
    .stall          (stall),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .count          (count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs held from just after one rising edge to just after the next.
  task automatic cycle(input logic cap, input logic [WIDTH-1:0] d, input logic rdy,
                       input logic clr, input logic expect_push);
    capture        = cap;
    bus_in         = d;
    out_ready      = rdy;
    clear_overflow = clr;
    if (expect_push) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake must deliver the oldest outstanding word.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got %0h expected no word", out_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          bad++;
          $display("FAIL pop_data: got %0h expected %0h at %0t", out_data, e, $time);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; capture = 1'b0; bus_in = '0; out_ready = 1'b0; clear_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_ovf", 32'(overflow), 0);

    // Single word
    cycle(1'b1, 4'hA, 1'b0, 1'b0, 1'b1);
    chk("single_valid", 32'(out_valid), 1);
    chk("single_data", 32'(out_data), 32'hA);
    chk("single_count", 32'(count), 1);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("single_count_after", 32'(count), 0);
    chk("single_valid_after", 32'(out_valid), 0);

    // Fill, overflow, drain, clear
    for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b1);
    chk("fill_count", 32'(count), 4);
    chk("fill_stall", 32'(stall), 1);
    chk("fill_ovf_pre", 32'(overflow), 0);
    cycle(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    chk("drop_ovf", 32'(overflow), 1);
    chk("drop_count", 32'(count), 4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("drain_count", 32'(count), 0);
    chk("drain_stall", 32'(stall), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("ovf_clear", 32'(overflow), 0);

    // Full with simultaneous pop and push, then set/clear collision
    for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 4'h9, 1'b1, 1'b0, 1'b1);
    chk("fullpp_count", 32'(count), 4);
    chk("fullpp_ovf", 32'(overflow), 0);
    chk("fullpp_stall", 32'(stall), 1);
    cycle(1'b1, 4'h7, 1'b0, 1'b1, 1'b0);
    chk("collide_ovf", 32'(overflow), 1);
    chk("collide_count", 32'(count), 4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("fullpp_drained", 32'(count), 0);
    cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("ovf_clear2", 32'(overflow), 0);

    // Pointer wrap: streaming with ready held high
    for (int i = 0; i < 10; i++) begin
      logic [WIDTH-1:0] w;
      w = 4'((i * 5 + 3) & 15);
      cycle(1'b1, w, 1'b1, 1'b0, 1'b1);
      chk("wrap_valid", 32'(out_valid), 1);
      chk("wrap_data", 32'(out_data), 32'(w));
      chk("wrap_count", 32'(count), 1);
      chk("wrap_stall", 32'(stall), 0);
    end
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("wrap_empty", 32'(count), 0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i + 12), 1'b0, 1'b0, 1'b1);
    chk("mid_count_pre", 32'(count), 3);
    capture = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_count", 32'(count), 0);
    chk("mid_stall", 32'(stall), 0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    cycle(1'b1, 4'hB, 1'b0, 1'b0, 1'b1);
    chk("post_rst_data", 32'(out_data), 32'hB);
    chk("post_rst_count", 32'(count), 1);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_port.md
Name: output_port

Overview:
- Downstream consumer of the 4-bit CPU system bus.
- When control decodes an OUT operation, it pulses `capture`. The block latches the current bus word into a small FIFO.
- The FIFO drains to an external host/testbench through a valid/ready handshake.
- When the FIFO is full, it asserts `stall`, which control ORs into `halt_pc` so the program waits for the host.

Parameters:
- WIDTH, default `WORD_SIZE` (4): data word width, equal to the system bus width.
- DEPTH, default 4: FIFO entries. Must be a power of two and at least 2.
- ADDR_W, default $clog2(DEPTH): pointer width. Derived; do not override.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset; clears all state while low.
- capture, input, 1: one-cycle strobe from control; enqueue `bus_in` this cycle.
- bus_in, input, WIDTH: system bus, sampled only when `capture` is 1.
- stall, output, 1: FIFO full; control must hold the PC/micro-step.
- out_data, output, WIDTH: head-of-FIFO word; 0 when empty.
- out_valid, output, 1: head word valid (count != 0).
- out_ready, input, 1: host accepts the head word this cycle.
- count, output, ADDR_W+1: current occupancy, 0..DEPTH.
- overflow, output, 1: sticky flag; a capture was dropped while full.
- clear_overflow, input, 1: synchronous clear of `overflow`.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Outputs: out_valid=0, out_data=0, stall=0.
  - Storage array is not reset.
  - Reset mid-operation discards all queued words immediately; no drain.
- Handshake and push/pop:
  - pop = out_valid & out_ready.
  - push = capture & (!full | pop).
  - full = (count == DEPTH).
  - out_valid is not gated by out_ready; the host may hold ready high continuously.
- Latency: a word captured into an empty FIFO appears on out_data/out_valid on the next cycle. There is no same-cycle bypass.
- Enqueue: on push, mem[wr_ptr] <= bus_in and wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Dequeue: on pop, rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- Full with simultaneous pop: if full, capture and pop occur together, the capture is accepted and count stays at DEPTH. No overflow is flagged.
- Dropped capture: capture while full with no pop drops the word and leaves pointers unchanged.
  - overflow <= 1 on the next edge.
  - overflow stays high until clear_overflow=1 or reset.
- Overflow set/clear collision: if a dropped capture and clear_overflow=1 occur in the same cycle, set wins and overflow stays 1.
- stall: combinational, equal to full. It is independent of out_ready, to avoid a combinational path from the host into control.
- out_data: mem[rd_ptr] when count != 0, else 0. This keeps the bus-style OR-combine safe.
- Pointer wrap: both pointers wrap at DEPTH; full and empty are distinguished by count, not by pointer equality.
- capture with X on bus_in while stalled is harmless because the word is dropped. Control must not rely on the dropped value.
- No internal FSM beyond the occupancy counter. The block is fully synchronous except for reset.

Decomposition:
- Add to the shared `defines.vh`:
  - `OUT_FIFO_DEPTH` (4).
  - `MEM_MICRO_INSTRUCTION` encoding for OUT, if not already present.
- WIDTH binds to `WORD_SIZE`.
- One sub-module: `output_fifo_ram` holds the DEPTH×WIDTH register array.
  - Inputs: write enable, write address, write data.
  - Asynchronous read at rd_ptr.
- Pointer, count and overflow logic stay in output_port.
- In `system`:
  - Instantiate output_port.
  - Drive capture from control.
  - OR stall into halt_pc.
  - Do not put out_data on the internal bus.

Test Plan:
- Reset then idle. Pulse reset low for 2 cycles and release, no capture → count=0, out_valid=0, out_data=0, stall=0, overflow=0.
- Single word. capture with bus_in=4'hA and out_ready=0 → next cycle out_valid=1, out_data=A, count=1. Raise out_ready for 1 cycle → count=0, out_valid=0.
- Fill and overflow. Capture 1,2,3,4 with out_ready=0 → count=4, stall=1. Capture 5 → dropped and overflow=1. Drain with out_ready=1 → outputs 1,2,3,4 in order. Pulse clear_overflow → overflow=0.
- Full with simultaneous pop/push. FIFO full of 1..4; in one cycle out_ready=1 and capture with bus_in=9 → count stays 4, overflow=0, stall stays 1. Drained order is 2,3,4,9.
- Pointer wrap. Stream 10 words with out_ready held at 1 and capture every cycle → every word appears exactly once, in order, one cycle after capture. count never exceeds 1 and stall never asserts.
- Reset mid-operation. With count=3, assert reset low asynchronously mid-cycle → out_valid, count and stall drop to 0 immediately. After release, the first new capture of B appears at out_data=B.
